instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ir_decode.sv | 29 ++
 rtl/instr_fetch_ctrl.sv | 77 +++++++
 tb/tb_instr_fetch_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch/execute state encoding, major opcodes and
// the fixed reset and halt addresses.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [5:0] SPECIAL = 6'd0;
  localparam logic [5:0] REGIMM  = 6'd1;
  localparam logic [5:0] J       = 6'd2;
  localparam logic [5:0] JAL     = 6'd3;
  localparam logic [5:0] BEQ     = 6'd4;
  localparam logic [5:0] BNE     = 6'd5;
  localparam logic [5:0] BLEZ    = 6'd6;
  localparam logic [5:0] BGTZ    = 6'd7;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDRESS = 32'h0000_0000;

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction helpers: byte-swaps the little-endian memory word
// into IR order and slices the held IR into its raw (unextended) fields.
module ir_decode (
  input  logic [31:0] readdata_i,
  input  logic [31:0] ir_i,
  output logic [31:0] ir_swap_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] offset_o,
  output logic [25:0] instr_index_o
);

  assign ir_swap_o = {readdata_i[7:0], readdata_i[15:8],
                      readdata_i[23:16], readdata_i[31:24]};

  assign opcode_o      = ir_i[31:26];
  assign rs_o          = ir_i[25:21];
  assign rt_o          = ir_i[20:16];
  assign rd_o          = ir_i[15:11];
  assign shamt_o       = ir_i[10:6];
  assign funct_o       = ir_i[5:0];
  assign offset_o      = ir_i[15:0];
  assign instr_index_o = ir_i[25:0];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/execute sequencer: issues instruction reads at pc_address, holds the
// IR through EXEC and halts permanently on a fetch from address zero.
module instr_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_address,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        stall,
  output logic        cycle_1,
  output logic        cycle_2,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] offset,
  output logic [25:0] instr_index,
  output logic        active
);

  state_e      state_q;
  logic [31:0] ir_q;
  logic [31:0] ir_swap;
  logic        halt_fetch;

  ir_decode u_ir_decode (
    .readdata_i    (readdata),
    .ir_i          (ir_q),
    .ir_swap_o     (ir_swap),
    .opcode_o      (opcode),
    .rs_o          (rs),
    .rt_o          (rt),
    .rd_o          (rd),
    .shamt_o       (shamt),
    .funct_o       (funct),
    .offset_o      (offset),
    .instr_index_o (instr_index)
  );

  assign halt_fetch = (pc_address == HALT_ADDRESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      case (state_q)
        IDLE:   state_q <= FETCH;
        FETCH: begin
          // Halt check wins over a ready memory so address zero is never read.
          if (halt_fetch) begin
            state_q <= HALTED;
          end else if (!waitrequest) begin
            ir_q    <= ir_swap;
            state_q <= EXEC;
          end
        end
        EXEC:   if (!stall) state_q <= FETCH;
        HALTED: state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address = pc_address;
  assign cycle_1 = (state_q == FETCH);
  assign read    = cycle_1 && !halt_fetch;
  assign cycle_2 = (state_q == EXEC) && !stall;
  assign active  = (state_q == FETCH) || (state_q == EXEC);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a per-cycle behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        stall;
  logic        cycle_1;
  logic        cycle_2;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic        active;

  int checks = 0;
  int errors = 0;

  instr_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc_address  (pc_address),
    .address     (address),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .stall       (stall),
    .cycle_1     (cycle_1),
    .cycle_2     (cycle_2),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .offset      (offset),
    .instr_index (instr_index),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: where the CPU is in its instruction (idle / fetching / executing /
  // stopped) and the instruction word it holds.
  localparam int M_IDLE = 0, M_FETCHING = 1, M_EXECUTING = 2, M_STOPPED = 3;
  int          m_where = M_IDLE;
  logic [31:0] m_ir = '0;
  bit          m_valid = 0;

  function automatic logic [31:0] mem_to_ir(input logic [31:0] w);
    return {<<8{w}};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_where = M_IDLE;
      m_ir    = '0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_where == M_IDLE) m_where = M_FETCHING;
      else if (m_where == M_FETCHING) begin
        if (pc_address == 0) m_where = M_STOPPED;
        else if (!waitrequest) begin
          m_ir    = mem_to_ir(readdata);
          m_where = M_EXECUTING;
        end
      end else if (m_where == M_EXECUTING && !stall) m_where = M_FETCHING;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_read",    32'(read),    32'(m_where == M_FETCHING && pc_address != 0));
      chk("m_cycle_1", 32'(cycle_1), 32'(m_where == M_FETCHING));
      chk("m_cycle_2", 32'(cycle_2), 32'(m_where == M_EXECUTING && !stall));
      chk("m_active",  32'(active),  32'(m_where == M_FETCHING || m_where == M_EXECUTING));
      chk("m_excl",    32'(cycle_1 & cycle_2), 32'h0);
      chk("m_address", address, pc_address);
      chk("m_opcode",  32'(opcode),      m_ir / 32'h0400_0000);
      chk("m_rs",      32'(rs),          (m_ir >> 21) % 32);
      chk("m_rt",      32'(rt),          (m_ir >> 16) % 32);
      chk("m_rd",      32'(rd),          (m_ir >> 11) % 32);
      chk("m_shamt",   32'(shamt),       (m_ir >> 6) % 32);
      chk("m_funct",   32'(funct),       m_ir % 64);
      chk("m_offset",  32'(offset),      m_ir % 32'h1_0000);
      chk("m_index",   32'(instr_index), m_ir % 32'h0400_0000);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pc_address = RESET_VECTOR; waitrequest = 1'b0;
    readdata = 32'h0800_0024; stall = 1'b0;

    cyc();
    @(negedge clk);
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_ir", 32'(instr_index), 32'h0);

    // cycle 1: IDLE after reset release
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("idle_cycle_1", 32'(cycle_1), 32'h0);
    chk("idle_active", 32'(active), 32'h0);

    // cycle 2: FETCH
    cyc();
    @(negedge clk);
    chk("c2_read", 32'(read), 32'h1);
    chk("c2_cycle_1", 32'(cycle_1), 32'h1);

    // cycle 3: EXEC; waitrequest here must be ignored
    cyc(); waitrequest = 1'b1; readdata = 32'h4433_2211;
    @(negedge clk);
    chk("c3_opcode", 32'(opcode), 32'd9);
    chk("c3_offset", 32'(offset), 32'h0008);
    chk("c3_cycle_2", 32'(cycle_2), 32'h1);

    // FETCH held by waitrequest for 3 cycles, loads on the 4th
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("wait_read", 32'(read), 32'h1);
      chk("wait_ir_held", 32'(opcode), 32'd9);
    end
    cyc(); waitrequest = 1'b0;
    @(negedge clk);
    chk("wait4_cycle_1", 32'(cycle_1), 32'h1);
    chk("wait4_ir_held", 32'(offset), 32'h0008);
    cyc(); readdata = 32'h0800_0024;
    @(negedge clk);
    chk("wait_load_opcode", 32'(opcode), 32'(BEQ));
    chk("wait_load_offset", 32'(offset), 32'h3344);

    // stall for 2 EXEC cycles; stall in FETCH is ignored
    cyc(); stall = 1'b1;
    @(negedge clk);
    chk("stall_in_fetch", 32'(cycle_1), 32'h1);
    for (int i = 0; i < 2; i++) begin
      cyc(); readdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall_cycle_2", 32'(cycle_2), 32'h0);
      chk("stall_opcode", 32'(opcode), 32'd9);
    end
    cyc(); stall = 1'b0; readdata = 32'hFFFF_0010;
    @(negedge clk);
    chk("stall_done_c2", 32'(cycle_2), 32'h1);
    chk("stall_done_off", 32'(offset), 32'h0008);

    // back-to-back: IR words 1000_FFFF (BEQ) then 0C00_0001 (JAL)
    cyc();
    @(negedge clk);
    chk("b2b_f1", 32'(cycle_1), 32'h1);
    cyc(); readdata = 32'h0100_000C;
    @(negedge clk);
    chk("b2b_beq", 32'(opcode), 32'(BEQ));
    chk("b2b_beq_off", 32'(offset), 32'hFFFF);
    chk("b2b_e1", 32'(cycle_2), 32'h1);
    cyc();
    @(negedge clk);
    chk("b2b_f2", 32'(cycle_1), 32'h1);
    cyc(); pc_address = HALT_ADDRESS;
    @(negedge clk);
    chk("b2b_jal", 32'(opcode), 32'(JAL));
    chk("b2b_jal_idx", 32'(instr_index), 32'h1);
    chk("exec_pc0_c2", 32'(cycle_2), 32'h1);

    // halting fetch at address zero
    cyc();
    @(negedge clk);
    chk("halt_fetch_read", 32'(read), 32'h0);
    chk("halt_fetch_active", 32'(active), 32'h1);
    cyc();
    @(negedge clk);
    chk("halted_active", 32'(active), 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      pc_address = $urandom | 32'h4;
      waitrequest = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      readdata = $urandom;
      @(negedge clk);
      chk("halted_stays", 32'({active, read, cycle_1, cycle_2}), 32'h0);
      chk("halted_ir", 32'(opcode), 32'(JAL));
    end

    // reset pulsed in FETCH while waitrequest is high
    cyc(); reset = 1'b1; stall = 1'b0;
    cyc(); reset = 1'b0; pc_address = RESET_VECTOR; waitrequest = 1'b1;
    readdata = 32'h0800_0024;
    @(negedge clk);
    chk("rst2_ir_zero", 32'(opcode), 32'h0);
    cyc();
    @(negedge clk);
    chk("rst2_fetch_read", 32'(read), 32'h1);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("rstw_read", 32'(read), 32'h0);
    chk("rstw_ir", 32'(instr_index), 32'h0);
    cyc();
    @(negedge clk);
    chk("rstw_refetch", 32'(cycle_1), 32'h1);
    chk("rstw_ir_still0", 32'(offset), 32'h0);
    waitrequest = 1'b0;

    // reset during EXEC
    cyc(); stall = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("rste_opcode", 32'(opcode), 32'd9);
    cyc(); reset = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rste_cycle_2", 32'(cycle_2), 32'h0);
    chk("rste_active", 32'(active), 32'h0);
    cyc();
    @(negedge clk);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
